// File: rtl/io_timer_intc.sv
// Peripheral end of the CPU's IN/OUT/timer/interrupt signals: OUT registers, IN mux,
// prescaled 16-bit down-counter with a two-state FSM, and two pending interrupt sources.
module io_timer_intc #(
    parameter int DATA_W    = 8,
    parameter int PRESC_W   = 8,
    parameter int PRESC_DIV = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_out,
    input  logic [1:0]        out_port,
    input  logic [DATA_W-1:0] out_data,
    input  logic [1:0]        in_port,
    output logic [DATA_W-1:0] in_data,
    input  logic              timer_e,
    input  logic [DATA_W-1:0] ext_in,
    input  logic              ext_irq,
    input  logic [1:0]        intr_ack,
    output logic [DATA_W-1:0] leds,
    output logic              intr1,
    output logic              intr2
);
    localparam int CNT_W = 2 * DATA_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [PRESC_W-1:0]  presc_reg, presc_next;
    logic [CNT_W-1:0]    reload_reg;
    logic [DATA_W-1:0]   leds_reg;
    logic [2:0]          ctrl_reg;
    logic [DATA_W-1:0]   ext_s1_reg, ext_s2_reg;
    logic [2:0]          irq_sync_reg;
    logic                pend1_reg, pend2_reg;
    logic                expire;
    logic                tick;
    logic                running;

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_reg <= '0;
            ctrl_reg <= '0;
        end else if (we_out) begin
            if (out_port == 2'd0) leds_reg <= out_data;
            if (out_port == 2'd3) ctrl_reg <= out_data[2:0];
        end
    end

    // Reload is written one DATA_W-wide lane per OUT port (port1 low, port2 high).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_reload
            always_ff @(posedge clk) begin
                if (reset)
                    reload_reg[gi*DATA_W +: DATA_W] <= '0;
                else if (we_out && out_port == 2'(gi + 1))
                    reload_reg[gi*DATA_W +: DATA_W] <= out_data;
            end
        end
    endgenerate

    // irq_sync_reg[1] is the synchronized level, [2] its previous value for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_s1_reg   <= '0;
            ext_s2_reg   <= '0;
            irq_sync_reg <= '0;
        end else begin
            ext_s1_reg   <= ext_in;
            ext_s2_reg   <= ext_s1_reg;
            irq_sync_reg <= {irq_sync_reg[1:0], ext_irq};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            presc_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            presc_reg <= presc_next;
        end
    end

    assign tick = (presc_reg == PRESC_W'(PRESC_DIV - 1));

    // A restart in RUN takes priority over a coincident tick and discards its expiry.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        presc_next = presc_reg;
        expire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (timer_e) begin
                    count_next = reload_reg;
                    presc_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (timer_e) begin
                    count_next = reload_reg;
                    presc_next = '0;
                end else if (tick) begin
                    presc_next = '0;
                    if (count_reg != '0) begin
                        count_next = count_reg - CNT_W'(1);
                    end else begin
                        expire = 1'b1;
                        if (ctrl_reg[2]) count_next = reload_reg;
                        else             state_next = IDLE;
                    end
                end else begin
                    presc_next = presc_reg + PRESC_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Set has priority over a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend1_reg <= 1'b0;
            pend2_reg <= 1'b0;
        end else begin
            pend1_reg <= expire | (pend1_reg & ~intr_ack[0]);
            pend2_reg <= (irq_sync_reg[1] & ~irq_sync_reg[2]) | (pend2_reg & ~intr_ack[1]);
        end
    end

    assign running = (state_reg == RUN);

    always_comb begin
        in_data = '0;
        case (in_port)
            2'd0: in_data = ext_s2_reg;
            2'd1: in_data = count_reg[DATA_W-1:0];
            2'd2: in_data = count_reg[CNT_W-1:DATA_W];
            2'd3: in_data = {{(DATA_W-3){1'b0}}, running, pend2_reg, pend1_reg};
            default: in_data = '0;
        endcase
    end

    assign leds  = leds_reg;
    assign intr1 = pend1_reg & ctrl_reg[0];
    assign intr2 = pend2_reg & ctrl_reg[1];
endmodule

// File: tb/tb_io_timer_intc.sv
// Bench for io_timer_intc: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a cycle-counting behavioural model.
module tb_io_timer_intc;
    localparam int DIV = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we_out = 1'b0;
    logic [1:0] out_port = '0;
    logic [7:0] out_data = '0;
    logic [1:0] in_port = '0;
    logic [7:0] in_data;
    logic       timer_e = 1'b0;
    logic [7:0] ext_in = '0;
    logic       ext_irq = 1'b0;
    logic [1:0] intr_ack = '0;
    logic [7:0] leds;
    logic       intr1, intr2;

    int n_tests = 0;
    int n_fail  = 0;

    io_timer_intc #(.DATA_W(8), .PRESC_W(8), .PRESC_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .we_out(we_out), .out_port(out_port),
        .out_data(out_data), .in_port(in_port), .in_data(in_data),
        .timer_e(timer_e), .ext_in(ext_in), .ext_irq(ext_irq),
        .intr_ack(intr_ack), .leds(leds), .intr1(intr1), .intr2(intr2)
    );

    always #5 clk = ~clk;

    // Model: counts cycles until the next tick instead of a prescaler value.
    logic [7:0]  m_leds;
    int          m_reload;
    logic [2:0]  m_ctrl;
    int          m_count;
    bit          m_running;
    int          m_left;
    bit          m_pend1, m_pend2;
    logic [7:0]  m_ext [2];
    bit          m_irq [3];

    task automatic model_step();
        bit expire = 0;
        int old_reload = m_reload;
        logic [2:0] old_ctrl = m_ctrl;
        bit rise = m_irq[1] && !m_irq[2];
        if (reset) begin
            m_leds = 0; m_reload = 0; m_ctrl = 0; m_count = 0; m_running = 0;
            m_left = DIV; m_pend1 = 0; m_pend2 = 0;
            m_ext[0] = 0; m_ext[1] = 0;
            m_irq[0] = 0; m_irq[1] = 0; m_irq[2] = 0;
            return;
        end
        if (we_out) begin
            case (out_port)
                2'd0: m_leds = out_data;
                2'd1: m_reload = (m_reload & 'hFF00) | int'(out_data);
                2'd2: m_reload = (m_reload & 'h00FF) | (int'(out_data) << 8);
                default: m_ctrl = out_data[2:0];
            endcase
        end
        if (timer_e) begin
            m_count = old_reload; m_left = DIV; m_running = 1;
        end else if (m_running) begin
            m_left--;
            if (m_left == 0) begin
                m_left = DIV;
                if (m_count > 0) m_count--;
                else begin
                    expire = 1;
                    if (old_ctrl[2]) m_count = old_reload;
                    else m_running = 0;
                end
            end
        end
        m_pend1 = expire || (m_pend1 && !intr_ack[0]);
        m_pend2 = rise || (m_pend2 && !intr_ack[1]);
        m_ext[1] = m_ext[0]; m_ext[0] = ext_in;
        m_irq[2] = m_irq[1]; m_irq[1] = m_irq[0]; m_irq[0] = ext_irq;
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_in;
        case (in_port)
            2'd0: exp_in = m_ext[1];
            2'd1: exp_in = 8'(m_count);
            2'd2: exp_in = 8'(m_count >> 8);
            default: exp_in = {5'b0, m_running, m_pend2, m_pend1};
        endcase
        check("leds", 16'(leds), 16'(m_leds));
        check("intr1", 16'(intr1), 16'(m_pend1 && m_ctrl[0]));
        check("intr2", 16'(intr2), 16'(m_pend2 && m_ctrl[1]));
        check("in_data", 16'(in_data), 16'(exp_in));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic out_wr(input logic [1:0] p, input logic [7:0] d);
        we_out = 1; out_port = p; out_data = d;
        tick();
        we_out = 0;
    endtask

    task automatic read_port(input logic [1:0] p, output logic [7:0] d);
        in_port = p;
        #1;
        d = in_data;
    endtask

    task automatic wait_intr1(output int n);
        n = 0;
        do begin tick(); n++; end while (!intr1 && n < 400);
    endtask

    task automatic wait_intr2(output int n);
        n = 0;
        do begin tick(); n++; end while (!intr2 && n < 400);
    endtask

    initial begin
        int n;
        logic [7:0] d;

        tick(); tick();
        reset = 0;
        check("reset_intr1", 16'(intr1), 16'h0);
        read_port(2'd3, d); check("reset_p3", 16'(d), 16'h00);

        // One-shot timer, reload 3
        out_wr(2'd1, 8'h03); out_wr(2'd2, 8'h00); out_wr(2'd3, 8'h01);
        timer_e = 1; tick(); timer_e = 0;
        wait_intr1(n);
        check("oneshot_latency", 16'(n), 16'(4 * DIV));
        read_port(2'd3, d); check("oneshot_p3", 16'(d), 16'h01);

        // Auto-reload period and ack/set collision
        out_wr(2'd3, 8'h05);
        intr_ack = 2'b01; tick(); intr_ack = 0;
        timer_e = 1; tick(); timer_e = 0;
        wait_intr1(n);
        check("auto_first", 16'(n), 16'(4 * DIV));
        intr_ack = 2'b01; tick(); intr_ack = 0;
        wait_intr1(n);
        check("auto_period", 16'(n + 1), 16'(4 * DIV));
        intr_ack = 2'b01; tick(); intr_ack = 0;
        repeat (4 * DIV - 2) tick();
        intr_ack = 2'b01; tick();
        check("ack_vs_set", 16'(intr1), 16'h1);
        tick(); intr_ack = 0;
        check("ack_clears", 16'(intr1), 16'h0);
        out_wr(2'd3, 8'h00);
        repeat (5 * DIV) tick();

        // External interrupt edge
        intr_ack = 2'b11; tick(); intr_ack = 0;
        out_wr(2'd3, 8'h02);
        ext_irq = 1;
        wait_intr2(n);
        check("irq_latency", 16'(n), 16'h3);
        repeat (5) tick();
        check("irq_held", 16'(intr2), 16'h1);
        intr_ack = 2'b10; tick(); intr_ack = 0;
        repeat (10) tick();
        check("irq_no_retrigger", 16'(intr2), 16'h0);
        ext_irq = 0; repeat (4) tick();
        out_wr(2'd3, 8'h00);
        ext_irq = 1; repeat (4) tick();
        check("irq_masked", 16'(intr2), 16'h0);
        read_port(2'd3, d); check("irq_masked_pend", 16'(d[1]), 16'h1);
        ext_irq = 0; intr_ack = 2'b11; tick(); intr_ack = 0;

        // Restart on the tick cycle discards that expiry
        out_wr(2'd1, 8'h00); out_wr(2'd3, 8'h01);
        timer_e = 1; tick(); timer_e = 0;
        repeat (DIV - 1) tick();
        timer_e = 1; tick(); timer_e = 0;
        check("restart_no_expire", 16'(intr1), 16'h0);
        wait_intr1(n);
        check("restart_latency", 16'(n), 16'(DIV));

        // Reset mid-count
        out_wr(2'd0, 8'h77); out_wr(2'd1, 8'h02); out_wr(2'd3, 8'h05);
        timer_e = 1; tick(); timer_e = 0;
        wait_intr1(n);
        tick();
        reset = 1; tick(); reset = 0;
        check("rst_intr1", 16'(intr1), 16'h0);
        check("rst_leds", 16'(leds), 16'h00);
        read_port(2'd1, d); check("rst_p1", 16'(d), 16'h00);
        read_port(2'd2, d); check("rst_p2", 16'(d), 16'h00);
        out_wr(2'd3, 8'h01);
        timer_e = 1; tick(); timer_e = 0;
        wait_intr1(n);
        check("post_rst_latency", 16'(n), 16'(DIV));

        // Switch sync and LED write
        in_port = 2'd0; ext_in = 8'hA5;
        tick(); check("ext_one_cycle", 16'(in_data), 16'h00);
        tick(); check("ext_two_cycles", 16'(in_data), 16'hA5);
        out_wr(2'd0, 8'h3C);
        check("leds_write", 16'(leds), 16'h3C);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(499) == 0);
            we_out   = ($urandom_range(9) == 0);
            out_port = 2'($urandom_range(3));
            case (out_port)
                2'd1: out_data = 8'($urandom_range(4));
                2'd2: out_data = ($urandom_range(5) == 0) ? 8'h01 : 8'h00;
                default: out_data = 8'($urandom);
            endcase
            in_port  = 2'($urandom_range(3));
            timer_e  = ($urandom_range(39) == 0);
            if ($urandom_range(7) == 0) ext_in = 8'($urandom);
            if ($urandom_range(9) == 0) ext_irq = ~ext_irq;
            intr_ack = ($urandom_range(5) == 0) ? 2'($urandom_range(3)) : 2'b00;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
